cnn_flow_controller: RTL and testbench

- Top-level sequencing FSM for the capture → send → single-PE → 3x3 systolic array → 2x2 systolic array → display flow.
- Waits in idle for a run request, then advances one stage each time that stage's done signal is seen.
- Exposes one-hot state flags that enable the datapath sub-blocks.
- Returns to idle when the display stage has shown its last frame.

---
 rtl/cnn_flow_controller_pkg.sv | 18 +
 rtl/ctrl_watchdog.sv | 43 ++++
 rtl/cnn_flow_controller.sv | 84 ++++++++
 tb/tb_cnn_flow_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_flow_controller_pkg.sv
// rtl/cnn_flow_controller_pkg.sv - shared state encoding and default constants for the CNN flow controller
package cnn_flow_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_SEND    = 3'd2,
        S_PE      = 3'd3,
        S_SA3     = 3'd4,
        S_SA2     = 3'd5,
        S_DISPLAY = 3'd6
    } state_t;

    localparam int DISP_W_DEF          = 3;
    localparam int LAST_DISPLAY_DEF    = 4;
    localparam int unsigned WDOG_CYCLES_DEF = 1024;

endpackage

// File: rtl/ctrl_watchdog.sv
// rtl/ctrl_watchdog.sv - per-stage timeout counter with sticky error flag (used under CTRL_WATCHDOG_EN)
module ctrl_watchdog
    import cnn_flow_controller_pkg::*;
#(
    parameter int unsigned CYCLES = WDOG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic clear,
    input  logic accept_run,
    output logic expire,
    output logic timeout_err
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || !active) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expire = active && (cnt_q == CW'(CYCLES - 1));

    // A fresh run clears the error on the same edge that leaves IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (accept_run) begin
            timeout_err <= 1'b0;
        end else if (expire) begin
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: rtl/cnn_flow_controller.sv
// rtl/cnn_flow_controller.sv - capture/send/PE/SA3/SA2/display sequencing FSM; CTRL_WATCHDOG_EN adds a stage timeout
module cnn_flow_controller
    import cnn_flow_controller_pkg::*;
#(
    parameter int DISP_W = DISP_W_DEF,
    parameter logic [DISP_W-1:0] LAST_DISPLAY = DISP_W'(LAST_DISPLAY_DEF),
    parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              done_capture,
    input  logic              done_send,
    input  logic              done_PE,
    input  logic              done_SA_3x3,
    input  logic              done_SA_2x2,
    input  logic [DISP_W-1:0] current_display,
`ifdef CTRL_WATCHDOG_EN
    output logic              timeout_err,
`endif
    output logic              state_idle,
    output logic              state_capture,
    output logic              state_send,
    output logic              state_PE,
    output logic              state_SA_3x3,
    output logic              state_SA_2x2,
    output logic              state_display
);

    state_t state_q;
    state_t state_d;
    logic   wdog_expire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only the current stage's done is examined, so stray dones never advance the flow.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (run)                              state_d = S_CAPTURE;
            S_CAPTURE: if (done_capture)                     state_d = S_SEND;
            S_SEND:    if (done_send)                        state_d = S_PE;
            S_PE:      if (done_PE)                          state_d = S_SA3;
            S_SA3:     if (done_SA_3x3)                      state_d = S_SA2;
            S_SA2:     if (done_SA_2x2)                      state_d = S_DISPLAY;
            S_DISPLAY: if (current_display == LAST_DISPLAY)  state_d = S_IDLE;
            default:                                         state_d = S_IDLE;
        endcase
        if (wdog_expire) begin
            state_d = S_IDLE;
        end
    end

`ifdef CTRL_WATCHDOG_EN
    ctrl_watchdog #(
        .CYCLES (WDOG_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .rst_n       (reset),
        .active      (state_q != S_IDLE),
        .clear       (state_d != state_q),
        .accept_run  ((state_q == S_IDLE) && run),
        .expire      (wdog_expire),
        .timeout_err (timeout_err)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    assign state_idle    = (state_q == S_IDLE);
    assign state_capture = (state_q == S_CAPTURE);
    assign state_send    = (state_q == S_SEND);
    assign state_PE      = (state_q == S_PE);
    assign state_SA_3x3  = (state_q == S_SA3);
    assign state_SA_2x2  = (state_q == S_SA2);
    assign state_display = (state_q == S_DISPLAY);

endmodule

// File: tb/tb_cnn_flow_controller.sv
// tb/tb_cnn_flow_controller.sv - directed table-driven bench for cnn_flow_controller (CTRL_WATCHDOG_EN adds timeout checks)
module tb_cnn_flow_controller;

    localparam logic [6:0] F_IDLE = 7'b1000000;
    localparam logic [6:0] F_CAP  = 7'b0100000;
    localparam logic [6:0] F_SEND = 7'b0010000;
    localparam logic [6:0] F_PE   = 7'b0001000;
    localparam logic [6:0] F_SA3  = 7'b0000100;
    localparam logic [6:0] F_SA2  = 7'b0000010;
    localparam logic [6:0] F_DISP = 7'b0000001;

    // dones packed as {capture, send, PE, SA3, SA2}
    localparam logic [4:0] D_NONE = 5'b00000;
    localparam logic [4:0] D_CAP  = 5'b10000;
    localparam logic [4:0] D_SEND = 5'b01000;
    localparam logic [4:0] D_PE   = 5'b00100;
    localparam logic [4:0] D_SA3  = 5'b00010;
    localparam logic [4:0] D_SA2  = 5'b00001;
    localparam logic [4:0] D_ALL  = 5'b11111;

    typedef struct {
        logic       run;
        logic [4:0] dones;
        logic [2:0] disp;
        logic [6:0] exp_flags;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       run;
    logic       done_capture, done_send, done_PE, done_SA_3x3, done_SA_2x2;
    logic [2:0] current_display;
    logic       state_idle, state_capture, state_send, state_PE;
    logic       state_SA_3x3, state_SA_2x2, state_display;
`ifdef CTRL_WATCHDOG_EN
    logic       timeout_err;
`endif

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    cnn_flow_controller #(.WDOG_CYCLES(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .run             (run),
        .done_capture    (done_capture),
        .done_send       (done_send),
        .done_PE         (done_PE),
        .done_SA_3x3     (done_SA_3x3),
        .done_SA_2x2     (done_SA_2x2),
        .current_display (current_display),
`ifdef CTRL_WATCHDOG_EN
        .timeout_err     (timeout_err),
`endif
        .state_idle      (state_idle),
        .state_capture   (state_capture),
        .state_send      (state_send),
        .state_PE        (state_PE),
        .state_SA_3x3    (state_SA_3x3),
        .state_SA_2x2    (state_SA_2x2),
        .state_display   (state_display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] flags();
        return {state_idle, state_capture, state_send, state_PE,
                state_SA_3x3, state_SA_2x2, state_display};
    endfunction

    function automatic vec_t mk(logic r, logic [4:0] d, logic [2:0] c, logic [6:0] e);
        vec_t v;
        v.run = r; v.dones = d; v.disp = c; v.exp_flags = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_onehot(input string name);
        total++;
        if ($countones(flags()) != 1) begin
            bad++;
            $display("FAIL %s onehot: got %b want exactly one bit", name, flags());
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] d, input logic [2:0] c);
        run = r;
        {done_capture, done_send, done_PE, done_SA_3x3, done_SA_2x2} = d;
        current_display = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, D_NONE, 3'd0);
        #1;
        chk("reset_async", flags(), F_IDLE);
        step();
        chk("reset_edge", flags(), F_IDLE);
        reset = 1'b1;

        // Full flow with waits, stray dones, display exit and back-to-back run.
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1'b0, D_NONE, 3'd0, F_IDLE));
        vecs.push_back(mk(1'b1, D_NONE, 3'd0, F_CAP));
        vecs.push_back(mk(1'b1, D_NONE, 3'd0, F_CAP));
        vecs.push_back(mk(1'b0, D_SEND | D_PE, 3'd4, F_CAP));
        vecs.push_back(mk(1'b0, D_NONE, 3'd0, F_CAP));
        vecs.push_back(mk(1'b0, D_CAP, 3'd0, F_SEND));
        vecs.push_back(mk(1'b0, D_PE | D_SA3 | D_SA2, 3'd0, F_SEND));
        vecs.push_back(mk(1'b0, D_PE | D_SA3 | D_SA2, 3'd0, F_SEND));
        vecs.push_back(mk(1'b0, D_ALL, 3'd0, F_PE));
        vecs.push_back(mk(1'b0, D_NONE, 3'd0, F_PE));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, D_NONE, 3'd0, F_PE));
        vecs.push_back(mk(1'b0, D_PE, 3'd0, F_SA3));
        vecs.push_back(mk(1'b0, D_PE, 3'd0, F_SA3));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, D_NONE, 3'd0, F_SA3));
        vecs.push_back(mk(1'b0, D_SA3, 3'd0, F_SA2));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, D_CAP, 3'd4, F_SA2));
        vecs.push_back(mk(1'b0, D_SA2, 3'd0, F_DISP));
        vecs.push_back(mk(1'b0, D_SA2, 3'd0, F_DISP));
        vecs.push_back(mk(1'b0, D_NONE, 3'd1, F_DISP));
        vecs.push_back(mk(1'b0, D_NONE, 3'd2, F_DISP));
        vecs.push_back(mk(1'b0, D_NONE, 3'd3, F_DISP));
        vecs.push_back(mk(1'b1, D_NONE, 3'd5, F_DISP));
        vecs.push_back(mk(1'b0, D_ALL, 3'd7, F_DISP));
        vecs.push_back(mk(1'b0, D_NONE, 3'd0, F_DISP));
        vecs.push_back(mk(1'b1, D_NONE, 3'd4, F_IDLE));
        vecs.push_back(mk(1'b1, D_NONE, 3'd4, F_CAP));

        foreach (vecs[i]) begin
            drive(vecs[i].run, vecs[i].dones, vecs[i].disp);
            step();
            chk($sformatf("vec%0d", i), flags(), vecs[i].exp_flags);
            chk_onehot($sformatf("vec%0d", i));
        end

        // Walk to SA3, then assert reset between edges.
        drive(1'b0, D_CAP, 3'd0);  step(); chk("walk_send", flags(), F_SEND);
        drive(1'b0, D_SEND, 3'd0); step(); chk("walk_pe",   flags(), F_PE);
        drive(1'b0, D_PE, 3'd0);   step(); chk("walk_sa3",  flags(), F_SA3);
        drive(1'b0, D_NONE, 3'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_mid", flags(), F_IDLE);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_reset%0d", i), flags(), F_IDLE);
        end

`ifdef CTRL_WATCHDOG_EN
        drive(1'b1, D_NONE, 3'd0);
        step();
        chk("wd_enter", flags(), F_CAP);
        chk("wd_err0", {6'b0, timeout_err}, 7'd0);
        drive(1'b0, D_NONE, 3'd0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("wd_hold%0d", i), flags(), F_CAP);
        end
        step();
        chk("wd_expire", flags(), F_IDLE);
        chk("wd_err1", {6'b0, timeout_err}, 7'd1);
        step();
        chk("wd_sticky", {6'b0, timeout_err}, 7'd1);
        drive(1'b1, D_NONE, 3'd0);
        step();
        chk("wd_rerun", flags(), F_CAP);
        chk("wd_err_clr", {6'b0, timeout_err}, 7'd0);
        drive(1'b0, D_CAP, 3'd0);
        step();
        chk("wd_rerun_send", flags(), F_SEND);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
